// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Responder end of the execution-unit data-memory interface. Owns a
//   2^ADDR_W x DATA_W storage array. It serves single-cycle writes and
//   fixed-latency reads, and gives ready/valid status so the EU controller
//   can stall. After reset it writes INIT_VAL to every location. It does not
//   accept requests until that clear sequence is complete.
//
//   Read latency: a read accepted in cycle N returns data with rd_vld_o high
//   in cycle N+RD_LAT. RD_LAT must be in the range 1..7.
//
// Ports
//   clk                 clock, rising edge
//   rst                 synchronous reset, active low
//   data_mem_rd_enb_i   read request
//   data_mem_wr_enb_i   write request
//   data_mem_addr_i     request address (full range, no wrap)
//   data_mem_wr_data_i  write data
//   data_mem_rd_data_o  read data, registered; holds until the next read
//   data_mem_rd_vld_o   1-cycle pulse: rd_data_o carries a completed read
//   data_mem_rdy_o      a request presented this cycle is accepted
//   data_mem_err_o      1-cycle pulse: the previous cycle's request was dropped
//   init_done_o         clear sequence complete; sticky until reset
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 8,
  parameter int                 RD_LAT   = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_mem_rd_enb_i,
  input  logic              data_mem_wr_enb_i,
  input  logic [ADDR_W-1:0] data_mem_addr_i,
  input  logic [DATA_W-1:0] data_mem_wr_data_i,
  output logic [DATA_W-1:0] data_mem_rd_data_o,
  output logic              data_mem_rd_vld_o,
  output logic              data_mem_rdy_o,
  output logic              data_mem_err_o,
  output logic              init_done_o
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   init_cnt_q;
  logic [2:0]          lat_cnt_q;
  logic [ADDR_W-1:0]   rd_addr_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Request decode
  logic                rdy;
  logic                acc_rd;
  logic                acc_wr;
  logic                drop;
  logic                last_init;
  logic                lat_done;
  logic                rd_fire;
  logic [ADDR_W-1:0]   rd_sel_addr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments. Blocking
  // assignments here would make the result depend on the order in which the
  // simulator evaluates the blocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case. Without it, any path that
  // does not assign state_d would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (last_init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (acc_rd && (RD_LAT > 1)) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_done) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / decode logic
  // -------------------------------------------------------------------------
  always_comb begin
    rdy       = (state_q == ST_IDLE);
    acc_rd    = rdy && data_mem_rd_enb_i && !data_mem_wr_enb_i;
    acc_wr    = rdy && data_mem_wr_enb_i && !data_mem_rd_enb_i;
    // A request is dropped in two cases: it arrives while not ready, or it
    // asserts read and write in the same cycle.
    drop      = (data_mem_rd_enb_i || data_mem_wr_enb_i) &&
                (!rdy || (data_mem_rd_enb_i && data_mem_wr_enb_i));
    last_init = (state_q == ST_INIT) && (init_cnt_q == ADDR_W'(DEPTH - 1));
    // The counter is 1 in the last wait cycle. At the closing edge it reaches
    // 0, the storage is sampled, and the FSM goes back to IDLE. This makes
    // rdy and vld rise in the same cycle.
    lat_done  = (state_q == ST_RD_WAIT) && (lat_cnt_q == 3'd1);

    // With RD_LAT==1 the array is sampled at the accept edge itself.
    rd_fire     = (acc_rd && (RD_LAT == 1)) || lat_done;
    rd_sel_addr = (RD_LAT == 1) ? data_mem_addr_i : rd_addr_q;

    // The clear sequence and accepted writes share one write port.
    mem_we = 1'b0;
    mem_wa = data_mem_addr_i;
    mem_wd = data_mem_wr_data_i;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
      mem_wa = init_cnt_q;
      mem_wd = INIT_VAL;
    end else if (acc_wr) begin
      mem_we = 1'b1;
    end
  end

  assign data_mem_rdy_o = rdy;

  // -------------------------------------------------------------------------
  // Counters and captured read address
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      init_cnt_q <= '0;
      lat_cnt_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;

      if (acc_rd) begin
        lat_cnt_q <= LAT_LOAD;
        rd_addr_q <= data_mem_addr_i;
      end else if (state_q == ST_RD_WAIT) begin
        lat_cnt_q <= lat_cnt_q - 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  // NOTE: the array itself has no reset. The clear sequence initialises it,
  // so it can map onto plain RAM. Writes are still blocked while rst is low,
  // so a request made during reset cannot change the contents.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_wa] <= mem_wd;
  end

  // -------------------------------------------------------------------------
  // Registered status and read data
  // -------------------------------------------------------------------------
  // A reset aborts any read in flight, because rd_vld_o is cleared and the
  // FSM restarts in INIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_mem_rd_data_o <= '0;
      data_mem_rd_vld_o  <= 1'b0;
      data_mem_err_o     <= 1'b0;
      init_done_o        <= 1'b0;
    end else begin
      data_mem_rd_vld_o <= rd_fire;
      data_mem_err_o    <= drop;
      if (rd_fire)   data_mem_rd_data_o <= mem[rd_sel_addr];
      if (last_init) init_done_o        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Directed bench for two instances of data_mem_ctrl: u_lat1 (RD_LAT=1) and
//   u_lat3 (RD_LAT=3). The instances share clock and reset. Each has its own
//   request inputs. Inputs change 1 time unit after a rising edge, and the
//   outputs are examined at that same point. Each "cycle" below is therefore
//   the interval between two rising edges.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic       clk;
  logic       rst;

  logic       rd1, wr1;
  logic [7:0] addr1, wdat1;
  logic [7:0] rdat1;
  logic       vld1, rdy1, err1, done1;

  logic       rd3, wr3;
  logic [7:0] addr3, wdat3;
  logic [7:0] rdat3;
  logic       vld3, rdy3, err3, done3;

  int total;
  int bad;
  int n;
  logic saw_vld;

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .INIT_VAL(8'h00)) u_lat1 (
    .clk                (clk),
    .rst                (rst),
    .data_mem_rd_enb_i  (rd1),
    .data_mem_wr_enb_i  (wr1),
    .data_mem_addr_i    (addr1),
    .data_mem_wr_data_i (wdat1),
    .data_mem_rd_data_o (rdat1),
    .data_mem_rd_vld_o  (vld1),
    .data_mem_rdy_o     (rdy1),
    .data_mem_err_o     (err1),
    .init_done_o        (done1)
  );

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .INIT_VAL(8'h00)) u_lat3 (
    .clk                (clk),
    .rst                (rst),
    .data_mem_rd_enb_i  (rd3),
    .data_mem_wr_enb_i  (wr3),
    .data_mem_addr_i    (addr3),
    .data_mem_wr_data_i (wdat3),
    .data_mem_rd_data_o (rdat3),
    .data_mem_rd_vld_o  (vld3),
    .data_mem_rdy_o     (rdy3),
    .data_mem_err_o     (err3),
    .init_done_o        (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 8'h00; wdat1 = 8'h00;
    rd3 = 1'b0; wr3 = 1'b0; addr3 = 8'h00; wdat3 = 8'h00;

    // ---- reset state ----
    step();
    step();
    check("rst_rdy",  32'(rdy1),  32'h0);
    check("rst_vld",  32'(vld1),  32'h0);
    check("rst_err",  32'(err1),  32'h0);
    check("rst_done", 32'(done1), 32'h0);
    check("rst_data", 32'(rdat1), 32'h0);

    // ---- clear sequence: rdy low for exactly 256 cycles ----
    rst = 1'b1;
    n = 0;
    while (rdy1 == 1'b0 && n < 300) begin
      n++;
      step();
    end
    check("init_len",   32'(n),     32'd256);
    check("init_done",  32'(done1), 32'h1);
    check("init_rdy3",  32'(rdy3),  32'h1);
    check("init_done3", 32'(done3), 32'h1);

    // ---- read after clear ----
    rd1 = 1'b1; addr1 = 8'h7F;
    step();
    rd1 = 1'b0;
    check("clr_rd_vld",  32'(vld1),  32'h1);
    check("clr_rd_data", 32'(rdat1), 32'h00);
    step();
    check("clr_vld_pulse", 32'(vld1), 32'h0);

    // ---- write then read next cycle (RD_LAT=1) ----
    wr1 = 1'b1; addr1 = 8'h3C; wdat1 = 8'hA5;
    step();
    check("wr_no_vld", 32'(vld1), 32'h0);
    wr1 = 1'b0; rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("raw_vld",  32'(vld1),  32'h1);
    check("raw_data", 32'(rdat1), 32'hA5);

    // ---- three writes, then back-to-back reads ----
    wr1 = 1'b1; addr1 = 8'h00; wdat1 = 8'h11;
    step();
    addr1 = 8'h01; wdat1 = 8'h22;
    step();
    addr1 = 8'hFF; wdat1 = 8'hEE;
    step();
    wr1 = 1'b0; rd1 = 1'b1; addr1 = 8'h00;
    step();
    check("b2b_vld0",  32'(vld1),  32'h1);
    check("b2b_data0", 32'(rdat1), 32'h11);
    addr1 = 8'h01;
    step();
    check("b2b_vld1",  32'(vld1),  32'h1);
    check("b2b_data1", 32'(rdat1), 32'h22);
    addr1 = 8'hFF;
    step();
    rd1 = 1'b0;
    check("b2b_vld2",  32'(vld1),  32'h1);
    check("b2b_data2", 32'(rdat1), 32'hEE);
    step();
    check("b2b_vld_end", 32'(vld1),  32'h0);
    check("data_hold",   32'(rdat1), 32'hEE);

    // ---- simultaneous rd and wr is dropped ----
    rd1 = 1'b1; wr1 = 1'b1; addr1 = 8'h10; wdat1 = 8'h55;
    step();
    rd1 = 1'b0; wr1 = 1'b0;
    check("conf_err", 32'(err1), 32'h1);
    check("conf_vld", 32'(vld1), 32'h0);
    step();
    check("conf_err_pulse", 32'(err1), 32'h0);
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("conf_mem_vld",  32'(vld1),  32'h1);
    check("conf_mem_data", 32'(rdat1), 32'h00);

    // ---- a write in the vld cycle does not disturb that read ----
    wr1 = 1'b1; addr1 = 8'h20; wdat1 = 8'h01;
    step();
    wr1 = 1'b0; rd1 = 1'b1;
    step();
    rd1 = 1'b0; wr1 = 1'b1; wdat1 = 8'h99;
    check("vldwr_rdy",  32'(rdy1),  32'h1);
    check("vldwr_data", 32'(rdat1), 32'h01);
    step();
    wr1 = 1'b0;
    check("vldwr_hold", 32'(rdat1), 32'h01);
    check("vldwr_vld",  32'(vld1),  32'h0);
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("vldwr_new", 32'(rdat1), 32'h99);

    // ---- RD_LAT=3 timing and a read dropped during the wait ----
    wr3 = 1'b1; addr3 = 8'h40; wdat3 = 8'h3C;
    step();
    wr3 = 1'b0; rd3 = 1'b1;
    step();                                   // accepted at this edge (cycle N)
    check("l3_n1_rdy", 32'(rdy3), 32'h0);     // cycle N+1
    check("l3_n1_vld", 32'(vld3), 32'h0);
    step();                                   // read held during N+1 is dropped
    rd3 = 1'b0;
    check("l3_n2_rdy", 32'(rdy3), 32'h0);     // cycle N+2
    check("l3_n2_err", 32'(err3), 32'h1);
    check("l3_n2_vld", 32'(vld3), 32'h0);
    step();
    check("l3_n3_vld",  32'(vld3),  32'h1);   // cycle N+3
    check("l3_n3_rdy",  32'(rdy3),  32'h1);
    check("l3_n3_data", 32'(rdat3), 32'h3C);
    check("l3_n3_err",  32'(err3),  32'h0);
    step();
    check("l3_n4_vld", 32'(vld3), 32'h0);
    step();
    check("l3_n5_vld", 32'(vld3), 32'h0);

    // ---- reset during a RD_LAT=3 read aborts it and restarts the clear ----
    rd3 = 1'b1; addr3 = 8'h40;
    step();                                   // accepted
    rd3 = 1'b0; rst = 1'b0;
    step();                                   // reset sampled
    rst = 1'b1;
    check("abort_vld",  32'(vld3),  32'h0);
    check("abort_rdy",  32'(rdy3),  32'h0);
    check("abort_err",  32'(err3),  32'h0);
    check("abort_done", 32'(done3), 32'h0);
    check("abort_data", 32'(rdat3), 32'h00);
    n = 0;
    saw_vld = 1'b0;
    while (rdy3 == 1'b0 && n < 300) begin
      if (vld3) saw_vld = 1'b1;
      n++;
      step();
    end
    check("abort_init_len", 32'(n),       32'd256);
    check("abort_no_vld",   32'(saw_vld), 32'h0);
    check("abort_done_set", 32'(done3),   32'h1);
    rd3 = 1'b1;
    step();
    rd3 = 1'b0;
    step();
    step();
    check("reclr_vld",  32'(vld3),  32'h1);
    check("reclr_data", 32'(rdat3), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
